// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - RV32M mul/div opcodes, FSM states and EX result-mux select
package ex_muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    // Encoding is funct3 of OP with funct7 = 0000001
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_e;

    typedef enum logic [3:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_AND,
        ALUOP_OR,
        ALUOP_XOR,
        ALUOP_SLL,
        ALUOP_SRL,
        ALUOP_SRA,
        ALUOP_SLT,
        ALUOP_SLTU,
        ALUOP_LUI,
        ALUOP_MULDIV
    } alu_op_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic op_signed_a(input muldiv_op_e op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_signed_b(input muldiv_op_e op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - EX-stage handshake between pipeline control and the mul/div unit
interface ex_muldiv_if
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    muldiv_op_e            op_i;
    logic [DATA_WIDTH-1:0] rs1_i;
    logic [DATA_WIDTH-1:0] rs2_i;
    logic                  flush_i;
    logic                  stall_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] result_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, flush_i,
        input  stall_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, flush_i,
        output stall_o, done_o, result_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - RV32M multi-cycle multiply/divide; MULDIV_FAST_MUL_EN gives 1-cycle MUL*
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_muldiv_if.slave    md
);
    localparam int W = DATA_WIDTH;

    muldiv_state_e  state;
    logic [4:0]     count;
    muldiv_op_e     op_q;
    logic           neg_q;
    logic           rem_neg_q;
    logic [W-1:0]   opb_q;
    logic [2*W-1:0] acc;
    logic           done_q;
    logic [W-1:0]   result_q;

    logic           is_div;
    logic           neg_a;
    logic           neg_b;
    logic [W-1:0]   a_abs;
    logic [W-1:0]   b_abs;
    logic           special;
    logic [W-1:0]   special_res;

    always_comb begin
        is_div      = op_is_div(md.op_i);
        neg_a       = op_signed_a(md.op_i) && md.rs1_i[W-1];
        neg_b       = op_signed_b(md.op_i) && md.rs2_i[W-1];
        a_abs       = neg_a ? -md.rs1_i : md.rs1_i;
        b_abs       = neg_b ? -md.rs2_i : md.rs2_i;
        special     = 1'b0;
        special_res = '0;
        if (is_div) begin
            if (md.rs2_i == '0) begin
                special     = 1'b1;
                special_res = md.op_i[1] ? md.rs1_i : '1;
            end else if ((md.op_i inside {DIV, REM}) && (md.rs1_i == {1'b1, {(W-1){1'b0}}})
                         && (md.rs2_i == '1)) begin
                special     = 1'b1;
                special_res = (md.op_i == DIV) ? md.rs1_i : '0;
            end
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [W:0]     fast_a;
    logic [W:0]     fast_b;
    logic [2*W-1:0] fast_prod;
    logic [W-1:0]   fast_res;

    // Low 64 bits of the 33x33 signed product cover every MUL* result
    always_comb begin
        fast_a    = {op_signed_a(md.op_i) && md.rs1_i[W-1], md.rs1_i};
        fast_b    = {op_signed_b(md.op_i) && md.rs2_i[W-1], md.rs2_i};
        fast_prod = {{(W-1){fast_a[W]}}, fast_a} * {{(W-1){fast_b[W]}}, fast_b};
        fast_res  = (md.op_i == MUL) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
    end
`endif

    logic           div_q;
    logic [W:0]     adder_a;
    logic [W:0]     adder_b;
    logic [W:0]     adder_sum;
    logic           q_bit;
    logic [2*W-1:0] acc_next;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic [W-1:0]   prod_hi_neg;
    logic [W-1:0]   fixed_res;

    // Shared adder: divide subtracts the divisor from the shifted remainder,
    // multiply adds the multiplicand into the upper product half.
    always_comb begin
        div_q     = op_is_div(op_q);
        adder_a   = div_q ? {1'b0, acc[2*W-2:W-1]} : {1'b0, acc[2*W-1:W]};
        adder_b   = div_q ? {1'b1, ~opb_q} : {1'b0, opb_q};
        adder_sum = adder_a + adder_b + {{W{1'b0}}, div_q};
        q_bit     = 1'b0;
        if (div_q) begin
            // acc MSB shifted out means the partial remainder already exceeds 2^32
            q_bit    = acc[2*W-1] | ~adder_sum[W];
            acc_next = q_bit ? {adder_sum[W-1:0], acc[W-2:0], 1'b1} : {acc[2*W-2:0], 1'b0};
        end else begin
            acc_next = acc[0] ? {adder_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
        end

        quot        = acc_next[W-1:0];
        rem         = acc_next[2*W-1:W];
        prod_hi_neg = ~acc_next[2*W-1:W] + {{(W-1){1'b0}}, (acc_next[W-1:0] == '0)};
        case (op_q)
            MUL:         fixed_res = acc_next[W-1:0];
            MULH,
            MULHSU:      fixed_res = neg_q ? prod_hi_neg : acc_next[2*W-1:W];
            MULHU:       fixed_res = acc_next[2*W-1:W];
            DIV:         fixed_res = neg_q ? -quot : quot;
            DIVU:        fixed_res = quot;
            REM:         fixed_res = rem_neg_q ? -rem : rem;
            default:     fixed_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            op_q      <= MUL;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            opb_q     <= '0;
            acc       <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else if (md.flush_i) begin
            state  <= IDLE;
            count  <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (md.start_i) begin
                        op_q      <= md.op_i;
                        neg_q     <= neg_a ^ neg_b;
                        rem_neg_q <= neg_a;
                        opb_q     <= is_div ? b_abs : a_abs;
                        acc       <= {{W{1'b0}}, is_div ? a_abs : b_abs};
                        count     <= '0;
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state    <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!is_div) begin
                            result_q <= fast_res;
                            done_q   <= 1'b1;
                            state    <= DONE;
`endif
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    count <= count + 5'd1;
                    if (count == 5'(MULDIV_ITER - 1)) begin
                        result_q <= fixed_res;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign md.stall_o  = rst_n && !md.flush_i &&
                         (((state == IDLE) && md.start_i) || (state == CALC));
    assign md.done_o   = done_q;
    assign md.result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv (honours MULDIV_FAST_MUL_EN)
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ex_muldiv_if mdif ();

    ex_muldiv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (mdif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input muldiv_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int stall_cnt;
        @(negedge clk);
        mdif.start_i = 1'b1;
        mdif.op_i    = op;
        mdif.rs1_i   = a;
        mdif.rs2_i   = b;
        #1;
        check({tag, "/stall_T"}, 32'(mdif.stall_o), 32'd1);
        stall_cnt = 1;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            #1;
            if (mdif.done_o) break;
            if (mdif.stall_o) stall_cnt++;
        end
        check({tag, "/done_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "/stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
        check({tag, "/result"}, mdif.result_o, exp);
        check({tag, "/stall_done"}, 32'(mdif.stall_o), 32'd0);
        mdif.start_i = 1'b0;
    endtask

    initial begin
        int lat;
        int done_seen;

        mdif.start_i = 1'b1;
        mdif.op_i    = DIV;
        mdif.rs1_i   = 32'd100;
        mdif.rs2_i   = 32'd7;
        mdif.flush_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset/stall", 32'(mdif.stall_o), 32'd0);
        check("reset/done", 32'(mdif.done_o), 32'd0);
        check("reset/result", mdif.result_o, 32'd0);
        mdif.start_i = 1'b0;
        rst_n = 1'b1;

        run_op("div_100_m7", DIV, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
        run_op("rem_m100_7", REM, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 33);
        run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu_by0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_by0", REM, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu_m1", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("mul_7_m3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);

        // Back-to-back: start_i stays high, next instruction enters EX after the done cycle
        @(negedge clk);
        mdif.start_i = 1'b1;
        mdif.op_i    = DIVU;
        mdif.rs1_i   = 32'd10;
        mdif.rs2_i   = 32'd3;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            #1;
            if (mdif.done_o) break;
        end
        check("b2b/first_lat", 32'(lat), 32'd33);
        check("b2b/first_result", mdif.result_o, 32'd3);
        check("b2b/no_restart", 32'(mdif.stall_o), 32'd0);
        mdif.op_i = REMU;
        @(negedge clk);
        lat++;
        #1;
        check("b2b/second_stall", 32'(mdif.stall_o), 32'd1);
        while (lat < 150) begin
            @(negedge clk);
            lat++;
            #1;
            if (mdif.done_o) break;
        end
        check("b2b/second_lat", 32'(lat), 32'd67);
        check("b2b/second_result", mdif.result_o, 32'd1);
        mdif.start_i = 1'b0;

        // Flush at T+10 of a DIV
        @(negedge clk);
        mdif.start_i = 1'b1;
        mdif.op_i    = DIV;
        mdif.rs1_i   = 32'd100;
        mdif.rs2_i   = 32'hFFFF_FFF9;
        repeat (10) @(negedge clk);
        mdif.flush_i = 1'b1;
        #1;
        check("flush/stall_T10", 32'(mdif.stall_o), 32'd0);
        @(negedge clk);
        mdif.flush_i = 1'b0;
        mdif.start_i = 1'b0;
        #1;
        check("flush/stall_T11", 32'(mdif.stall_o), 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (mdif.done_o) done_seen++;
        end
        check("flush/no_done", 32'(done_seen), 32'd0);
        check("flush/result_kept", mdif.result_o, 32'd1);

        // Reset at T+10 of a DIV
        @(negedge clk);
        mdif.start_i = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid/stall_T10", 32'(mdif.stall_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mdif.start_i = 1'b0;
        #1;
        check("rstmid/stall_T11", 32'(mdif.stall_o), 32'd0);
        check("rstmid/result", mdif.result_o, 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (mdif.done_o) done_seen++;
        end
        check("rstmid/no_done", 32'(done_seen), 32'd0);

        run_op("post_rst_divu", DIVU, 32'd1000, 32'd7, 32'd142, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
